// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings and lane-mask helper for the data memory controller
//
// Contents:
//   SZ_BYTE / SZ_HALF / SZ_WORD  access size encodings (2'b11 is illegal)
//   state_e                      controller FSM states (IDLE, RD_WAIT)
//   lane_mask()                  byte-lane enables for a given size and addr[1:0]

package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  // Lane i covers bits [8*i+7:8*i] of the little-endian word.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// rtl/dm_load_align.sv - combinational load lane select with sign/zero extension
//
// Ports:
//   word  in  32  full memory word
//   size  in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   off   in  2   byte offset addr[1:0] of the access
//   uns   in  1   1 = zero-extend, 0 = sign-extend
//   data  out 32  right-aligned, extended load result

module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[off*8 +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - multi-cycle byte/half/word data memory with read latency and error reporting
//
// Optional feature macro: DM_PARITY_EN (per-byte even parity, reported on par_err).
//
// Ports:
//   clk       in  1       rising-edge clock
//   rst       in  1       asynchronous active-high reset
//   addr      in  ADDR_W  byte address
//   data      in  32      store data, right-aligned
//   MemRead   in  1       load request
//   MemWrite  in  1       store request
//   size      in  2       00 byte, 01 half, 10 word, 11 illegal
//   uns       in  1       zero-extend load when 1
//   DM_data   out 32      load result, held until the next load completes
//   rvalid    out 1       one-cycle pulse when DM_data updates
//   busy      out 1       load in flight; requests ignored
//   err       out 1       one-cycle pulse on a rejected request
//   par_err   out 1       parity mismatch on a completed load

module dm_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [31:0]       DM_data,
  output logic              rvalid,
  output logic              busy,
  output logic              err,
  output logic              par_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         size_q, off_q;
  logic               uns_q;

  logic [IDX_W-1:0]   req_idx;
  logic               misaligned, out_of_range, bad_req;
  logic               accept_rd, accept_wr, reject, load_done;
  logic [3:0]         wr_mask;
  logic [31:0]        wr_lanes;
  logic [31:0]        rd_word, rd_data;
  logic               par_mismatch;

  assign req_idx      = addr[IDX_W+1:2];
  assign misaligned   = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
  assign bad_req      = (MemRead && MemWrite) || (size == 2'b11) || misaligned || out_of_range;

  assign accept_rd = (state == IDLE) && MemRead  && !bad_req;
  assign accept_wr = (state == IDLE) && MemWrite && !bad_req && !rst;
  assign reject    = (state == IDLE) && (MemRead || MemWrite) && bad_req;

  assign busy = (state == RD_WAIT);

  // Replicate the right-aligned store data so every lane position sees its bytes.
  assign wr_mask = lane_mask(size, addr[1:0]);
  always_comb begin
    case (size)
      SZ_BYTE: wr_lanes = {4{data[7:0]}};
      SZ_HALF: wr_lanes = {2{data[15:0]}};
      default: wr_lanes = data;
    endcase
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept_rd) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_d   = IDLE;
          load_done = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The array is read at completion; stores cannot land during RD_WAIT,
  // so this matches the contents at accept time.
  assign rd_word = mem[idx_q];

  dm_load_align u_align (
    .word (rd_word),
    .size (size_q),
    .off  (off_q),
    .uns  (uns_q),
    .data (rd_data)
  );

`ifdef DM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_calc;

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      par_calc[l] = ^rd_word[l*8 +: 8];
    end
  end
  assign par_mismatch = |(lane_mask(size_q, off_q) & (par_calc ^ par_mem[idx_q]));
`else
  assign par_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) begin
          mem[req_idx][l*8 +: 8] <= wr_lanes[l*8 +: 8];
`ifdef DM_PARITY_EN
          par_mem[req_idx][l] <= ^wr_lanes[l*8 +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      DM_data <= 32'h0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rvalid  <= load_done;
      err     <= reject;
      par_err <= load_done && par_mismatch;
      if (accept_rd) begin
        idx_q  <= req_idx;
        size_q <= size;
        off_q  <= addr[1:0];
        uns_q  <= uns;
      end
      if (load_done) begin
        DM_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - scoreboard bench for dm_ctrl with a byte-array reference model

module tb_dm_ctrl;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       data = '0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              uns = 1'b0;
  logic [31:0]       DM_data;
  logic              rvalid, busy, err, par_err;

  dm_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data),
    .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .uns(uns),
    .DM_data(DM_data), .rvalid(rvalid), .busy(busy), .err(err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          c;
    logic [31:0] d;
    bit          pe;
  } ld_t;

  ld_t        ld_q[$];
  int         err_q[$];
  logic [7:0] mem_m [DEPTH*4];
  int         last_acc = -100;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = 32'(mem_m[a]);
        if (!u && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = 32'(mem_m[a]) + 256 * 32'(mem_m[a+1]);
        if (!u && v >= 32768) v = v - 65536;
      end
      default: v = 32'(mem_m[a]) + 256 * 32'(mem_m[a+1])
                 + 65536 * 32'(mem_m[a+2]) + 16777216 * 32'(mem_m[a+3]);
    endcase
    return v;
  endfunction

  // Drive one request and predict its outcome at the next rising edge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] d, input bit fix, input logic [31:0] fixv,
                       input bit pe);
    int  e;
    bit  bad;
    ld_t ent;
    @(posedge clk);
    #2;
    MemRead = rd; MemWrite = wr; addr = a; size = sz; uns = u; data = d;
    e = cyc + 1;
    if ((rd || wr) && e > last_acc + RD_LAT) begin
      bad = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
            (sz == 2'b10 && a[1:0] != 2'b00) || (a >= DEPTH * 4);
      if (bad) begin
        err_q.push_back(e);
      end else if (wr) begin
        mem_m[a] = d[7:0];
        if (sz != 2'b00) mem_m[a+1] = d[15:8];
        if (sz == 2'b10) begin
          mem_m[a+2] = d[23:16];
          mem_m[a+3] = d[31:24];
        end
      end else begin
        ent.c  = e + RD_LAT;
        ent.d  = fix ? fixv : model_load(a, sz, u);
        ent.pe = pe;
        ld_q.push_back(ent);
        last_acc = e;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      MemRead = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    issue(1'b0, 1'b1, a, sz, 1'b0, d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit u);
    issue(1'b1, 1'b0, a, sz, u, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(RD_LAT);
  endtask

  task automatic ldc(input logic [31:0] a, input logic [1:0] sz, input bit u, input logic [31:0] x);
    issue(1'b1, 1'b0, a, sz, u, 32'h0, 1'b1, x, 1'b0);
    idle(RD_LAT);
  endtask

  bit  ee;
  ld_t pe_ent;
  always @(negedge clk) begin
    ee = 1'b0;
    if (err_q.size() != 0 && err_q[0] == cyc) begin
      ee = 1'b1;
      void'(err_q.pop_front());
    end
    check("err", 32'(err), 32'(ee));
    check("busy", 32'(busy), 32'(last_acc <= cyc && cyc < last_acc + RD_LAT));
    if (rvalid) begin
      if (ld_q.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        pe_ent = ld_q.pop_front();
        check("rvalid_cycle", cyc, pe_ent.c);
        check("DM_data", DM_data, pe_ent.d);
        check("par_err", 32'(par_err), 32'(pe_ent.pe));
      end
    end else begin
      if (ld_q.size() != 0 && ld_q[0].c <= cyc) begin
        void'(ld_q.pop_front());
        check("rvalid_missing", 32'(rvalid), 32'h1);
      end
      check("par_err_idle", 32'(par_err), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    check("reset_DM_data", DM_data, 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 2'b10, $urandom);

    // word store/load and a misaligned word store
    st(32'd10, 2'b10, 32'd10);
    st(32'd8, 2'b10, 32'd10);
    ldc(32'd8, 2'b10, 1'b0, 32'd10);

    // byte lanes with sign/zero extension
    st(32'd0, 2'b10, 32'h11223344);
    st(32'd1, 2'b00, 32'h00000080);
    ldc(32'd1, 2'b00, 1'b0, 32'hFFFFFF80);
    ldc(32'd1, 2'b00, 1'b1, 32'h00000080);
    ldc(32'd0, 2'b10, 1'b0, 32'h11228044);

    // halfword, plus a misaligned half that must not write
    st(32'd6, 2'b01, 32'h0000BEEF);
    ldc(32'd6, 2'b01, 1'b0, 32'hFFFFBEEF);
    ldc(32'd6, 2'b01, 1'b1, 32'h0000BEEF);
    st(32'd5, 2'b01, 32'h00001234);
    ld(32'd4, 2'b10, 1'b0);

    // store during busy is ignored; boundary and read+write rejects
    issue(1'b1, 1'b0, 32'd12, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 32'd12, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    idle(1);
    ld(32'd12, 2'b10, 1'b0);
    st(32'(DEPTH * 4), 2'b10, 32'h1);
    issue(1'b1, 1'b1, 32'd16, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    idle(1);
    ld(32'd16, 2'b10, 1'b0);
    ld(32'(DEPTH * 4 - 4), 2'b10, 1'b0);

    // reset one cycle after a load is accepted
    issue(1'b1, 1'b0, 32'd8, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    MemRead = 1'b0;
    rst = 1'b1;
    ld_q.delete();
    err_q.delete();
    last_acc = -100;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_DM_data", DM_data, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(3);
    ldc(32'd8, 2'b10, 1'b0, 32'd10);
    ldc(32'd0, 2'b10, 1'b0, 32'h11228044);

    // randomized back-to-back traffic, including requests during busy
    for (int i = 0; i < 500; i++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, DEPTH * 4 - 1);
      if ($urandom_range(0, 15) == 0) a = DEPTH * 4 + $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue(r == 0 || (r >= 1 && r <= 4), r == 0 || (r >= 5 && r <= 8), a, sz,
            1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0, 1'b0);
    end
    idle(RD_LAT + 1);

`ifdef DM_PARITY_EN
    dut.mem[5] = dut.mem[5] ^ 32'h00000008;
    mem_m[20] = mem_m[20] ^ 8'h08;
    issue(1'b1, 1'b0, 32'd20, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(RD_LAT);
    issue(1'b1, 1'b0, 32'd21, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(RD_LAT);
`endif

    idle(RD_LAT + 3);
    if (ld_q.size() != 0 || err_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d loads and %0d errors still pending", ld_q.size(), err_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
